// File: rtl/window_generator.sv
// window_generator: 5x5 sliding-window producer over a raster-order pixel
// stream. Four line buffers hold the previous rows. A 25-entry shift register
// presents each complete window one cycle after its bottom-right pixel arrives.
module window_generator #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [15:0] pixel_in,
  output logic signed [15:0] window_out [0:4][0:4],
  output logic               window_valid,
  output logic               frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FOUR = CW'(4);
  localparam logic [RW-1:0] ROW_FOUR = RW'(4);

  // Position of the next pixel within the frame.
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;

  // Position used for this cycle's pixel; start forces it to (0,0).
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;

  logic          win_pos;
  logic          last_pixel;

  // Line buffers: index 0 is the newest completed row, index 3 the oldest.
  logic signed [15:0] lb [0:3][0:IMG_W-1];
  logic signed [15:0] lb_rd [0:3];

  logic signed [15:0] win_next [0:4][0:4];

  // Effective position and counter advance for the current cycle.
  always_comb begin
    eff_col    = start ? '0 : col_reg;
    eff_row    = start ? '0 : row_reg;
    col_next   = eff_col;
    row_next   = eff_row;
    win_pos    = (eff_row >= ROW_FOUR) && (eff_col >= COL_FOUR);
    last_pixel = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    if (in_valid) begin
      if (eff_col == COL_LAST) begin
        col_next = '0;
        row_next = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      end else begin
        col_next = eff_col + 1'b1;
      end
    end
  end

  // Read the column of stored pixels sitting above the incoming pixel.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lb_rd
      assign lb_rd[gi] = lb[gi][eff_col];
    end
  endgenerate

  // Shift every window row left and load the new rightmost column.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        win_next[i][j] = window_out[i][j+1];
      end
    end
    for (int i = 0; i < 4; i++) begin
      win_next[i][4] = lb_rd[3-i];
    end
    win_next[4][4] = pixel_in;
  end

  // Line buffers ripple one row older at the accepted column; contents are
  // never cleared because validity gating keeps stale rows hidden.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb[0][eff_col] <= pixel_in;
      for (int k = 1; k < 4; k++) begin
        lb[k][eff_col] <= lb[k-1][eff_col];
      end
    end
  end

  // Counters, window register and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg      <= '0;
      row_reg      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          window_out[i][j] <= '0;
        end
      end
    end else begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      window_valid <= in_valid && win_pos;
      frame_done   <= in_valid && last_pixel;
      if (in_valid) begin
        window_out <= win_next;
      end
    end
  end

endmodule
